// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ALU-op encodings and pipeline control structs for pipe_ctrl_unit.
// Optional jal support is selected with CTRL_JAL_EN in the decoder.
package pipe_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluOr    = 3'b011;
  localparam logic [2:0] AluSlt   = 3'b100;

  localparam logic [4:0] LinkReg = 5'd31;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic       illegal;
    logic [4:0] dest;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Later stages only carry the bits they still consume.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic [4:0] dest;
  } mem_ctrl_t;

  typedef struct packed {
    logic       mem_to_reg;
    logic       reg_write;
    logic       link;
    logic [4:0] dest;
  } wb_ctrl_t;

  function automatic mem_ctrl_t to_mem_ctrl(ctrl_t c);
    mem_ctrl_t m;
    m.mem_read   = c.mem_read;
    m.mem_write  = c.mem_write;
    m.mem_to_reg = c.mem_to_reg;
    m.reg_write  = c.reg_write;
    m.link       = c.link;
    m.dest       = c.dest;
    return m;
  endfunction

  function automatic wb_ctrl_t to_wb_ctrl(mem_ctrl_t m);
    wb_ctrl_t w;
    w.mem_to_reg = m.mem_to_reg;
    w.reg_write  = m.reg_write;
    w.link       = m.link;
    w.dest       = m.dest;
    return w;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational instruction decoder: IF/ID word to control bundle plus source-use flags.
// jal (000011) decodes only when CTRL_JAL_EN is defined; otherwise it is illegal.
import pipe_ctrl_pkg::*;

module ctrl_decode (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        is_jump
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = inst[31:26];
  assign rt = inst[20:16];
  assign rd = inst[15:11];

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_jump = 1'b0;
    // An all-zero word is the NOP bubble, not sll.
    if (inst != 32'b0) begin
      case (op)
        OpRtype: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = AluFunct;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = rd;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
        OpLw: begin
          ctrl.alu_src    = 1'b1;
          ctrl.alu_op     = AluAdd;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.dest       = rt;
          uses_rs         = 1'b1;
        end
        OpSw: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = AluAdd;
          ctrl.mem_write = 1'b1;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
        OpBeq, OpBne: begin
          ctrl.alu_op    = AluSub;
          ctrl.branch    = 1'b1;
          ctrl.branch_ne = (op == OpBne);
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
        OpAddi, OpOri, OpSlti: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = (op == OpOri)  ? AluOr  :
                           (op == OpSlti) ? AluSlt : AluAdd;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = rt;
          uses_rs        = 1'b1;
        end
        OpJ: begin
          is_jump = 1'b1;
        end
`ifdef CTRL_JAL_EN
        OpJal: begin
          ctrl.reg_write = 1'b1;
          ctrl.link      = 1'b1;
          ctrl.dest      = LinkReg;
          is_jump        = 1'b1;
        end
`endif
        default: begin
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall and branch/jump flush. Define CTRL_JAL_EN to enable jal.
import pipe_ctrl_pkg::*;

module pipe_ctrl_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        inst_id,
  input  logic               alu_zero,
  output logic               stall,
  output logic               flush_ifid,
  output logic               jump,
  output logic               pc_src,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [REG_AW-1:0]  ex_dest,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_mem_to_reg,
  output logic               wb_reg_write,
  output logic               wb_link,
  output logic [REG_AW-1:0]  wb_dest,
  output logic               illegal
);

  ctrl_t     id_ctrl;
  logic      id_uses_rs;
  logic      id_uses_rt;
  logic      id_is_jump;
  logic      load_use;

  ctrl_t     ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;

  ctrl_decode u_decode (
    .inst    (inst_id),
    .ctrl    (id_ctrl),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt),
    .is_jump (id_is_jump)
  );

  always_comb begin
    load_use = 1'b0;
    if (ex_q.mem_read && (ex_q.dest != 5'd0)) begin
      load_use = (id_uses_rs && (ex_q.dest == inst_id[25:21])) ||
                 (id_uses_rt && (ex_q.dest == inst_id[20:16]));
    end
  end

  // Priority: taken branch squashes everything, then load-use stall, then jump.
  always_comb begin
    pc_src     = ex_q.branch & (alu_zero ^ ex_q.branch_ne);
    stall      = load_use & ~pc_src;
    jump       = id_is_jump & ~pc_src & ~stall;
    flush_ifid = pc_src | jump;
  end

  always_comb begin
    ex_d  = (pc_src || stall) ? CTRL_BUBBLE : id_ctrl;
    mem_d = to_mem_ctrl(ex_q);
    wb_d  = to_wb_ctrl(mem_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q  <= CTRL_BUBBLE;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
  assign ex_dest       = REG_AW'(ex_q.dest);
  assign illegal       = ex_q.illegal;
  assign mem_read      = mem_q.mem_read;
  assign mem_write     = mem_q.mem_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_dest       = REG_AW'(wb_q.dest);

`ifdef CTRL_JAL_EN
  assign wb_link = wb_q.link;
`else
  // Decoder never sets link without jal; keep the output hard zero regardless.
  assign wb_link = wb_q.link & 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: models the pipeline as instruction words per stage.
module tb_pipe_ctrl_unit;

`ifdef CTRL_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_id = 32'h0C00_0040;
  logic        alu_zero = 1'b0;
  logic        stall, flush_ifid, jump, pc_src;
  logic        ex_reg_dst, ex_alu_src;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_dest, wb_dest;
  logic        mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_link, illegal;

  always #5 clock = ~clock;

  pipe_ctrl_unit #(.REG_AW(5), .ALUOP_W(3)) dut (
    .clock(clock), .reset(reset), .inst_id(inst_id), .alu_zero(alu_zero),
    .stall(stall), .flush_ifid(flush_ifid), .jump(jump), .pc_src(pc_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_dest(ex_dest), .mem_read(mem_read), .mem_write(mem_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_link(wb_link),
    .wb_dest(wb_dest), .illegal(illegal)
  );

  typedef struct packed {
    logic       stall, flush, jump, pc_src;
    logic       reg_dst, alu_src;
    logic [2:0] alu_op;
    logic [4:0] ex_dest;
    logic       illegal, mem_read, mem_write, mem_to_reg, reg_write, link;
    logic [4:0] wb_dest;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference: which instruction word occupies each stage (0 = bubble).
  logic [31:0] m_id = 32'h0, m_ex = 32'h0, m_mem = 32'h0, m_wb = 32'h0;
  bit          m_rst = 1'b1, m_pc_src = 1'b0, m_stall = 1'b0;

  function automatic bit known(logic [31:0] w);
    logic [5:0] op = w[31:26];
    return (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                       6'b001000, 6'b001101, 6'b001010, 6'b000010}) ||
           (JalEn && op == 6'b000011);
  endfunction

  function automatic bit real_op(logic [31:0] w, logic [5:0] op);
    return (w != 32'h0) && known(w) && (w[31:26] == op);
  endfunction

  function automatic bit f_ill(logic [31:0] w);
    return (w != 32'h0) && !known(w);
  endfunction

  function automatic bit f_writes(logic [31:0] w);
    return real_op(w, 6'b000000) || real_op(w, 6'b100011) || real_op(w, 6'b001000) ||
           real_op(w, 6'b001101) || real_op(w, 6'b001010) || real_op(w, 6'b000011);
  endfunction

  function automatic logic [4:0] f_dest(logic [31:0] w);
    if (real_op(w, 6'b000000)) return w[15:11];
    if (real_op(w, 6'b000011)) return 5'd31;
    if (f_writes(w)) return w[20:16];
    return 5'd0;
  endfunction

  function automatic logic [2:0] f_alu_op(logic [31:0] w);
    if (real_op(w, 6'b000000)) return 3'd2;
    if (real_op(w, 6'b000100) || real_op(w, 6'b000101)) return 3'd1;
    if (real_op(w, 6'b001101)) return 3'd3;
    if (real_op(w, 6'b001010)) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit f_alu_src(logic [31:0] w);
    return real_op(w, 6'b100011) || real_op(w, 6'b101011) || real_op(w, 6'b001000) ||
           real_op(w, 6'b001101) || real_op(w, 6'b001010);
  endfunction

  function automatic bit f_uses_rs(logic [31:0] w);
    return (w != 32'h0) && known(w) && !real_op(w, 6'b000010) && !real_op(w, 6'b000011);
  endfunction

  function automatic bit f_uses_rt(logic [31:0] w);
    return real_op(w, 6'b000000) || real_op(w, 6'b101011) ||
           real_op(w, 6'b000100) || real_op(w, 6'b000101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("flush_ifid", 32'(flush_ifid), 32'(e.flush));
      chk("jump", 32'(jump), 32'(e.jump));
      chk("pc_src", 32'(pc_src), 32'(e.pc_src));
      chk("ex_reg_dst", 32'(ex_reg_dst), 32'(e.reg_dst));
      chk("ex_alu_src", 32'(ex_alu_src), 32'(e.alu_src));
      chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu_op));
      chk("ex_dest", 32'(ex_dest), 32'(e.ex_dest));
      chk("illegal", 32'(illegal), 32'(e.illegal));
      chk("mem_read", 32'(mem_read), 32'(e.mem_read));
      chk("mem_write", 32'(mem_write), 32'(e.mem_write));
      chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.mem_to_reg));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(e.reg_write));
      chk("wb_link", 32'(wb_link), 32'(e.link));
      chk("wb_dest", 32'(wb_dest), 32'(e.wb_dest));
    end
  end

  // One clock: advance the model across the edge, apply new inputs, queue the expectation.
  task automatic step(input logic [31:0] inst, input logic az, input logic rst);
    exp_t e;
    bit   lu;
    @(posedge clock);
    if (m_rst) begin
      m_ex = 32'h0; m_mem = 32'h0; m_wb = 32'h0;
    end else begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (m_pc_src || m_stall) ? 32'h0 : m_id;
    end
    #1;
    inst_id = inst; alu_zero = az; reset = rst;
    m_id = inst; m_rst = rst;
    m_pc_src = (real_op(m_ex, 6'b000100) && az) || (real_op(m_ex, 6'b000101) && !az);
    lu = real_op(m_ex, 6'b100011) && (f_dest(m_ex) != 5'd0) &&
         ((f_uses_rs(m_id) && m_id[25:21] == f_dest(m_ex)) ||
          (f_uses_rt(m_id) && m_id[20:16] == f_dest(m_ex)));
    m_stall    = lu && !m_pc_src;
    e.stall    = m_stall;
    e.pc_src   = m_pc_src;
    e.jump     = !m_pc_src && !m_stall && (real_op(m_id, 6'b000010) || real_op(m_id, 6'b000011));
    e.flush    = m_pc_src || e.jump;
    e.reg_dst  = real_op(m_ex, 6'b000000);
    e.alu_src  = f_alu_src(m_ex);
    e.alu_op   = f_alu_op(m_ex);
    e.ex_dest  = f_dest(m_ex);
    e.illegal  = f_ill(m_ex);
    e.mem_read = real_op(m_mem, 6'b100011);
    e.mem_write  = real_op(m_mem, 6'b101011);
    e.mem_to_reg = real_op(m_wb, 6'b100011);
    e.reg_write  = f_writes(m_wb);
    e.link       = real_op(m_wb, 6'b000011);
    e.wb_dest    = f_dest(m_wb);
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] op;
    int unsigned k = $urandom_range(0, 11);
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [4:0] rd = 5'($urandom_range(0, 3));
    case (k)
      0: op = 6'b000000;  1: op = 6'b100011;  2: op = 6'b101011;
      3: op = 6'b000100;  4: op = 6'b000101;  5: op = 6'b001000;
      6: op = 6'b001101;  7: op = 6'b001010;  8: op = 6'b000010;
      9: op = 6'b000011;  10: return 32'h0;
      default: op = 6'($urandom);
    endcase
    return {op, rs, rt, rd, 11'($urandom)};
  endfunction

  localparam int NDir = 28;
  logic [31:0] dir_inst [NDir] = '{
    32'h0, 32'h0022_1820, 32'h0, 32'h0, 32'h0,
    32'h8C22_0000, 32'h0044_1820, 32'h0044_1820, 32'h0, 32'h0, 32'h0,
    32'h8C22_0000, 32'h00A4_1820, 32'h0, 32'h0,
    32'h1022_0004, 32'h8C22_0000, 32'h0, 32'h1022_0004, 32'h0,
    32'h0800_0040, 32'h0, 32'h0C00_0040, 32'h0, 32'h0, 32'h0, 32'hFC00_0000, 32'h0
  };
  bit dir_az [NDir] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int rst_at = int'($urandom_range(150, 300));
    step(32'h1234_5678, 1'b0, 1'b1);
    step(32'h8C22_0000, 1'b1, 1'b1);
    for (int i = 0; i < NDir; i++) step(dir_inst[i], dir_az[i], 1'b0);
    for (int i = 0; i < 500; i++) begin
      step(rand_inst(), 1'($urandom_range(0, 1)), (i == rst_at) ? 1'b1 : 1'b0);
    end
    step(32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
